// File: rtl/rgb_px_assembler.sv
// rgb_px_assembler: byte-to-RGB555 framer for the grayscale/Sobel pipeline.
// Two bytes per pixel (high byte first). It tracks column/row within the
// frame, drives the frame-level start handshake and flags a sof that
// arrives in the middle of a frame.
//
// state  | meaning
// -------+----------------------------------------------------------
// S_IDLE | no frame active; only a byte qualified by sof_i is accepted
// S_HI   | inside a frame, waiting for the high byte of the next pixel
// S_LO   | high byte latched, waiting for the low byte of the pixel
module rgb_px_assembler #(
  parameter int MAX_PIXEL_BITS = 15,
  parameter int IMG_W          = 160,
  parameter int IMG_H          = 120,
  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1,
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
  input  logic                      clk_i,
  input  logic                      nreset_i,
  input  logic                      enable_i,
  input  logic [7:0]                byte_i,
  input  logic                      byte_valid_i,
  input  logic                      sof_i,
  output logic [MAX_PIXEL_BITS-1:0] px_rgb_o,
  output logic                      px_valid_o,
  output logic                      start_o,
  output logic [COL_W-1:0]          col_o,
  output logic [ROW_W-1:0]          row_o,
  output logic                      frame_done_o,
  output logic                      err_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HI   = 2'd1,
    S_LO   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [6:0]                hi_q, hi_d;
  logic                      first_q, first_d;
  logic [COL_W-1:0]          col_q, col_d, col_nxt;
  logic [ROW_W-1:0]          row_q, row_d, row_nxt;
  logic [MAX_PIXEL_BITS-1:0] px_q, px_d;
  logic                      pxv_q, pxv_d;
  logic                      start_q, start_d;
  logic                      fd_q, fd_d;
  logic                      err_q, err_d;
  logic                      last_px;

  // Coordinates of the pixel that the next low byte would complete.
  // first_q distinguishes "counters cleared by sof" from a real pixel at (0,0).
  always_comb begin
    col_nxt = col_q;
    row_nxt = row_q;
    if (first_q) begin
      col_nxt = '0;
      row_nxt = '0;
    end else if (col_q == COL_W'(IMG_W - 1)) begin
      col_nxt = '0;
      row_nxt = row_q + ROW_W'(1);
    end else begin
      col_nxt = col_q + COL_W'(1);
    end
    last_px = (col_nxt == COL_W'(IMG_W - 1)) && (row_nxt == ROW_W'(IMG_H - 1));
  end

  // State register; enable_i low acts as a synchronous clear.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q <= S_IDLE;
    end else if (!enable_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a sof byte always lands in S_LO, abandoning any frame.
  always_comb begin
    state_d = state_q;
    if (byte_valid_i) begin
      unique case (state_q)
        S_IDLE: if (sof_i) state_d = S_LO;
        S_HI:   state_d = S_LO;
        S_LO: begin
          if (sof_i)        state_d = S_LO;
          else if (last_px) state_d = S_IDLE;
          else              state_d = S_HI;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Next values for the byte latch, counters and the registered outputs.
  always_comb begin
    hi_d    = hi_q;
    first_d = first_q;
    col_d   = col_q;
    row_d   = row_q;
    px_d    = px_q;
    pxv_d   = 1'b0;
    fd_d    = 1'b0;
    // start drops the cycle after the last pixel's strobe
    start_d = fd_q ? 1'b0 : start_q;
    err_d   = err_q;
    if (byte_valid_i) begin
      if (sof_i) begin
        hi_d    = byte_i[6:0];
        col_d   = '0;
        row_d   = '0;
        first_d = 1'b1;
        if (state_q != S_IDLE) err_d = 1'b1;
      end else if (state_q == S_HI) begin
        hi_d = byte_i[6:0];
      end else if (state_q == S_LO) begin
        px_d    = MAX_PIXEL_BITS'({hi_q, byte_i});
        pxv_d   = 1'b1;
        col_d   = col_nxt;
        row_d   = row_nxt;
        first_d = 1'b0;
        fd_d    = last_px;
        start_d = 1'b1;
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      hi_q    <= '0;
      first_q <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      px_q    <= '0;
      pxv_q   <= 1'b0;
      start_q <= 1'b0;
      fd_q    <= 1'b0;
      err_q   <= 1'b0;
    end else if (!enable_i) begin
      hi_q    <= '0;
      first_q <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      px_q    <= '0;
      pxv_q   <= 1'b0;
      start_q <= 1'b0;
      fd_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      hi_q    <= hi_d;
      first_q <= first_d;
      col_q   <= col_d;
      row_q   <= row_d;
      px_q    <= px_d;
      pxv_q   <= pxv_d;
      start_q <= start_d;
      fd_q    <= fd_d;
      err_q   <= err_d;
    end
  end

  assign px_rgb_o     = px_q;
  assign px_valid_o   = pxv_q;
  assign start_o      = start_q;
  assign col_o        = col_q;
  assign row_o        = row_q;
  assign frame_done_o = fd_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_rgb_px_assembler.sv
// Directed bench for rgb_px_assembler using a 2x2 frame.
module tb_rgb_px_assembler;

  logic        clk_i = 1'b0;
  logic        nreset_i = 1'b0;
  logic        enable_i = 1'b1;
  logic [7:0]  byte_i = 8'h00;
  logic        byte_valid_i = 1'b0;
  logic        sof_i = 1'b0;
  logic [14:0] px_rgb_o;
  logic        px_valid_o;
  logic        start_o;
  logic [0:0]  col_o;
  logic [0:0]  row_o;
  logic        frame_done_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  logic [7:0]  w_hi [4] = '{8'h00, 8'h7F, 8'h00, 8'h55};
  logic [7:0]  w_lo [4] = '{8'h1F, 8'hFF, 8'h00, 8'h55};
  logic [14:0] w_px [4] = '{15'h001F, 15'h7FFF, 15'h0000, 15'h5555};
  logic        w_col[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic        w_row[4] = '{1'b0, 1'b0, 1'b1, 1'b1};

  rgb_px_assembler #(
    .MAX_PIXEL_BITS(15),
    .IMG_W(2),
    .IMG_H(2)
  ) dut (
    .clk_i(clk_i),
    .nreset_i(nreset_i),
    .enable_i(enable_i),
    .byte_i(byte_i),
    .byte_valid_i(byte_valid_i),
    .sof_i(sof_i),
    .px_rgb_o(px_rgb_o),
    .px_valid_o(px_valid_o),
    .start_o(start_o),
    .col_o(col_o),
    .row_o(row_o),
    .frame_done_o(frame_done_o),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic s);
    @(negedge clk_i);
    byte_i = b;
    byte_valid_i = 1'b1;
    sof_i = s;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk_i);
      byte_valid_i = 1'b0;
      sof_i = 1'b0;
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_px"}, 32'(px_rgb_o), 32'h0);
    check({tag, "_pxv"}, 32'(px_valid_o), 32'h0);
    check({tag, "_start"}, 32'(start_o), 32'h0);
    check({tag, "_col"}, 32'(col_o), 32'h0);
    check({tag, "_row"}, 32'(row_o), 32'h0);
    check({tag, "_fd"}, 32'(frame_done_o), 32'h0);
    check({tag, "_err"}, 32'(err_o), 32'h0);
  endtask

  initial begin
    // reset state
    #12;
    check_all_zero("reset");
    @(negedge clk_i);
    nreset_i = 1'b1;

    // full 2x2 frame, back-to-back bytes, bit 7 of high byte ignored
    send(8'h7C, 1'b1);
    check("t1_sof_pxv", 32'(px_valid_o), 32'h0);
    check("t1_sof_start", 32'(start_o), 32'h0);
    send(8'h00, 1'b0);
    check("t1_p0_px", 32'(px_rgb_o), 32'h7C00);
    check("t1_p0_pxv", 32'(px_valid_o), 32'h1);
    check("t1_p0_col", 32'(col_o), 32'h0);
    check("t1_p0_row", 32'(row_o), 32'h0);
    check("t1_p0_start", 32'(start_o), 32'h1);
    check("t1_p0_fd", 32'(frame_done_o), 32'h0);
    idle(1);
    check("t1_gap_pxv", 32'(px_valid_o), 32'h0);
    check("t1_gap_px_held", 32'(px_rgb_o), 32'h7C00);
    check("t1_gap_start", 32'(start_o), 32'h1);
    send(8'h03, 1'b0);
    send(8'hE0, 1'b0);
    check("t1_p1_px", 32'(px_rgb_o), 32'h03E0);
    check("t1_p1_col", 32'(col_o), 32'h1);
    check("t1_p1_row", 32'(row_o), 32'h0);
    check("t1_p1_fd", 32'(frame_done_o), 32'h0);
    send(8'hFC, 1'b0);
    send(8'h00, 1'b0);
    check("t1_p2_px_bit7", 32'(px_rgb_o), 32'h7C00);
    check("t1_p2_col", 32'(col_o), 32'h0);
    check("t1_p2_row", 32'(row_o), 32'h1);
    send(8'h55, 1'b0);
    send(8'h55, 1'b0);
    check("t1_p3_px", 32'(px_rgb_o), 32'h5555);
    check("t1_p3_col", 32'(col_o), 32'h1);
    check("t1_p3_row", 32'(row_o), 32'h1);
    check("t1_p3_fd", 32'(frame_done_o), 32'h1);
    check("t1_p3_start", 32'(start_o), 32'h1);
    idle(1);
    check("t1_end_start", 32'(start_o), 32'h0);
    check("t1_end_fd", 32'(frame_done_o), 32'h0);
    check("t1_end_pxv", 32'(px_valid_o), 32'h0);
    check("t1_end_err", 32'(err_o), 32'h0);

    // wrap with gaps between bytes
    for (int i = 0; i < 4; i++) begin
      send(w_hi[i], (i == 0));
      idle(1);
      if (i > 0) check($sformatf("t2_gap_start_%0d", i), 32'(start_o), 32'h1);
      check($sformatf("t2_gap_pxv_%0d", i), 32'(px_valid_o), 32'h0);
      send(w_lo[i], 1'b0);
      check($sformatf("t2_px_%0d", i), 32'(px_rgb_o), 32'(w_px[i]));
      check($sformatf("t2_pxv_%0d", i), 32'(px_valid_o), 32'h1);
      check($sformatf("t2_col_%0d", i), 32'(col_o), 32'(w_col[i]));
      check($sformatf("t2_row_%0d", i), 32'(row_o), 32'(w_row[i]));
      check($sformatf("t2_fd_%0d", i), 32'(frame_done_o), (i == 3) ? 32'h1 : 32'h0);
      check($sformatf("t2_start_%0d", i), 32'(start_o), 32'h1);
      idle(2);
    end
    check("t2_end_start", 32'(start_o), 32'h0);

    // bytes without sof while idle are ignored
    send(8'h12, 1'b0);
    check("t3_b0_pxv", 32'(px_valid_o), 32'h0);
    send(8'h34, 1'b0);
    check("t3_b1_pxv", 32'(px_valid_o), 32'h0);
    check("t3_b1_start", 32'(start_o), 32'h0);
    send(8'h7C, 1'b1);
    check("t3_sof_pxv", 32'(px_valid_o), 32'h0);
    send(8'h00, 1'b0);
    check("t3_px", 32'(px_rgb_o), 32'h7C00);
    check("t3_pxv", 32'(px_valid_o), 32'h1);
    check("t3_col", 32'(col_o), 32'h0);
    check("t3_row", 32'(row_o), 32'h0);
    check("t3_err", 32'(err_o), 32'h0);

    // sof mid-frame, then again mid-pixel
    send(8'h7C, 1'b1);
    check("t4_sof1_err", 32'(err_o), 32'h1);
    check("t4_sof1_start", 32'(start_o), 32'h1);
    send(8'h03, 1'b1);
    check("t4_sof2_err", 32'(err_o), 32'h1);
    check("t4_sof2_start", 32'(start_o), 32'h1);
    check("t4_sof2_pxv", 32'(px_valid_o), 32'h0);
    send(8'hE0, 1'b0);
    check("t4_px", 32'(px_rgb_o), 32'h03E0);
    check("t4_col", 32'(col_o), 32'h0);
    check("t4_row", 32'(row_o), 32'h0);
    check("t4_err_sticky", 32'(err_o), 32'h1);
    check("t4_start", 32'(start_o), 32'h1);
    check("t4_fd", 32'(frame_done_o), 32'h0);

    // enable low for one cycle clears everything including err
    @(negedge clk_i);
    enable_i = 1'b0;
    byte_i = 8'h5A;
    byte_valid_i = 1'b1;
    sof_i = 1'b1;
    @(posedge clk_i);
    #1;
    check_all_zero("t5_en");
    @(negedge clk_i);
    enable_i = 1'b1;
    byte_valid_i = 1'b0;
    sof_i = 1'b0;
    send(8'h00, 1'b0);
    send(8'h11, 1'b0);
    check("t5_idle_pxv", 32'(px_valid_o), 32'h0);
    check("t5_idle_start", 32'(start_o), 32'h0);

    // async reset mid-frame after three pixels and an error
    send(8'h01, 1'b1);
    send(8'h02, 1'b0);
    check("t6_p0_px", 32'(px_rgb_o), 32'h0102);
    send(8'h03, 1'b0);
    send(8'h04, 1'b0);
    check("t6_p1_px", 32'(px_rgb_o), 32'h0304);
    check("t6_p1_col", 32'(col_o), 32'h1);
    send(8'h05, 1'b0);
    send(8'h06, 1'b0);
    check("t6_p2_px", 32'(px_rgb_o), 32'h0506);
    check("t6_p2_col", 32'(col_o), 32'h0);
    check("t6_p2_row", 32'(row_o), 32'h1);
    send(8'h7F, 1'b1);
    check("t6_err", 32'(err_o), 32'h1);
    #2;
    nreset_i = 1'b0;
    #1;
    check_all_zero("t6_rst");
    @(negedge clk_i);
    nreset_i = 1'b1;
    byte_valid_i = 1'b0;
    sof_i = 1'b0;
    send(8'h07, 1'b0);
    send(8'h08, 1'b0);
    check("t6_post_pxv", 32'(px_valid_o), 32'h0);
    send(8'h7C, 1'b1);
    send(8'h00, 1'b0);
    check("t6_new_px", 32'(px_rgb_o), 32'h7C00);
    check("t6_new_pxv", 32'(px_valid_o), 32'h1);
    check("t6_new_col", 32'(col_o), 32'h0);
    check("t6_new_row", 32'(row_o), 32'h0);
    check("t6_new_err", 32'(err_o), 32'h0);
    check("t6_new_start", 32'(start_o), 32'h1);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rgb_px_assembler.md
# rgb_px_assembler

Input-side framer for the grayscale/Sobel pipeline. It assembles RGB555 pixels from a byte-wide input port, two bytes per pixel, and tracks the column and row position within a frame. It drives the `start`/pixel handshake that the gray-scale core consumes: start high and held for the whole frame, with a new pixel presented on each strobe. It also flags framing errors.

## Interface
- MAX_PIXEL_BITS, 15, RGB555 pixel width, {R[4:0],G[4:0],B[4:0]}
- IMG_W, 160, pixels per line
- IMG_H, 120, lines per frame
- clk_i  in  1  clock
- nreset_i  in  1  reset, asynchronous, active-low
- enable_i  in  1  block enable; low = synchronous clear
- byte_i  in  8  input byte
- byte_valid_i  in  1  byte_i valid this cycle
- sof_i  in  1  start of frame; qualified by byte_valid_i, marks first (high) byte of frame
- px_rgb_o  out  MAX_PIXEL_BITS  assembled pixel, held between strobes
- px_valid_o  out  1  one-cycle strobe: new px_rgb_o
- start_o  out  1  frame-active level, feeds gray-scale core start_i
- col_o  out  $clog2(IMG_W)  column of current px_rgb_o
- row_o  out  $clog2(IMG_H)  row of current px_rgb_o
- frame_done_o  out  1  one-cycle strobe with last pixel of frame
- err_o  out  1  sticky framing error

## Operation
- Byte format: high byte = {x, R[4:0], G[4:3]} with bit 7 ignored; low byte = {G[2:0], B[4:0]}. Pixel = {hi[6:0], lo[7:0]}.
- FSM states: IDLE, HI, LO.
  - IDLE: ignores bytes without sof_i. On byte_valid_i & sof_i, latches the high byte, clears col/row, and goes to LO.
  - LO: on byte_valid_i & !sof_i, forms the pixel, registers px_rgb_o, pulses px_valid_o, and updates col_o/row_o. Next state is HI, or IDLE if this was the last pixel.
  - HI: on byte_valid_i & !sof_i, latches the high byte and goes to LO.
- Position: col_o/row_o give the coordinates of the pixel on px_rgb_o. The first pixel of a frame is (0,0).
  - col wraps at IMG_W-1 → 0 and row increments.
  - The last pixel is (IMG_W-1, IMG_H-1); frame_done_o is asserted with its px_valid_o.
- start_o:
  - Rises with the first px_valid_o of the frame.
  - Stays high through the last pixel's px_valid_o cycle.
  - Falls on the following cycle.
  - Stays high across byte gaps inside a frame.
- sof_i while in HI or LO (mid-frame, including mid-pixel):
  - Sets err_o.
  - Discards any partial high byte and abandons the old frame.
  - Treats the byte as the high byte of a new frame: counters cleared, state LO.
  - start_o stays high with no gap.
  - col_o/row_o restart at (0,0) on the next px_valid_o.
- byte_valid_i low: no state change. sof_i without byte_valid_i is ignored.
- enable_i low: next edge forces IDLE and zeros every output, including err_o. While low, all inputs are ignored.
- err_o clears only via reset or enable_i low.

## Timing
- Reset values: px_rgb_o=0, px_valid_o=0, start_o=0, col_o=0, row_o=0, frame_done_o=0, err_o=0, state IDLE.
- Minimum 2 cycles per pixel. Back-to-back bytes every cycle are sustained with no stalls and no backpressure.
- All outputs are registered.
  - A low byte sampled at edge N gives px_rgb_o, px_valid_o, col_o, row_o and frame_done_o valid after edge N; start_o rises then too.
  - The gray-scale core registers on edge N+1.
- err_o is set after the edge that samples the offending sof_i.
- Reset mid-frame: immediate (asynchronous) return to reset values. A byte with no sof_i after reset is ignored.

## Test plan
- Single pixel, IMG_W=2, IMG_H=1, enable_i=1:
  - Stimulus: bytes 0x7C(sof), 0x00.
  - Response: px_rgb_o=0x7C00, px_valid_o one cycle, (col,row)=(0,0), start_o high.
  - Then bytes 0x03, 0xE0 → 0x03E0 at (1,0) with frame_done_o; start_o low on the next cycle.
- Wrap with IMG_W=2, IMG_H=2:
  - Stimulus: four pixels 0x001F, 0x7FFF, 0x0000, 0x5555, with gap cycles between bytes.
  - Response: coordinates (0,0), (1,0), (0,1), (1,1); frame_done_o only on the 4th; start_o continuous; bit 7 of the high byte ignored (0xFC, 0x00 → 0x7C00).
- Bytes in IDLE without sof_i:
  - Stimulus: 0x12, 0x34, then 0x7C(sof), 0x00.
  - Response: no px_valid_o until the final byte; pixel 0x7C00 at (0,0).
- Mid-pixel sof:
  - Stimulus: 0x7C(sof), then 0x03(sof), then 0xE0.
  - Response: err_o=1; pixel 0x03E0 at (0,0); start_o never drops.
  - Then enable_i low for one cycle → all outputs 0, err_o=0.
- Async reset with nreset_i low mid-frame (after 3 pixels):
  - Response: all outputs 0 immediately, state IDLE.
  - After release, a fresh sof frame starts at (0,0) with err_o=0.
